airi5c_fetch_aligner: RTL and testbench

- Sits between the instruction-memory fetch interface and the C-extension decompression stage.
- Receives naturally aligned 32-bit fetch words and splits them into 16-bit parcels.
- Re-assembles 32-bit instructions that straddle word boundaries.
- Emits one raw instruction per handshake, together with its PC. A compressed instruction occupies bits [15:0]; bits [31:16] are don't-care.
- Handles redirects (branch, jump, trap), including targets at PC[1]=1.

---
 rtl/airi5c_fetch_aligner_pkg.sv | 21 ++
 rtl/airi5c_fetch_aligner_parcel_buffer.sv | 75 +++++++
 rtl/airi5c_fetch_aligner.sv | 114 +++++++++++
 tb/tb_airi5c_fetch_aligner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_fetch_aligner_pkg.sv
// Shared definitions for the fetch aligner: the parcel type, the compressed-parcel
// test, and the enum used to request parcel moves from the buffer.
package airi5c_fetch_aligner_pkg;

    localparam int          RVC_PARCEL_W     = 16;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef logic [RVC_PARCEL_W-1:0] parcel_t;

    // Number of parcels moved into or out of the buffer in one cycle.
    typedef enum logic [1:0] {
        MOVE_NONE = 2'd0,
        MOVE_ONE  = 2'd1,
        MOVE_TWO  = 2'd2
    } move_e;

    function automatic logic is_compressed(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/airi5c_fetch_aligner_parcel_buffer.sv
// Three-entry 16-bit parcel queue: pops 0/1/2 parcels from the head, then appends
// 0/1/2 new parcels directly behind the survivors in the same cycle.
module airi5c_fetch_aligner_parcel_buffer
    import airi5c_fetch_aligner_pkg::*;
(
    input  logic    clk,
    input  logic    nreset,
    input  logic    flush_i,
    input  move_e   pop_i,
    input  move_e   push_i,
    input  parcel_t push_lo_i,
    input  parcel_t push_hi_i,
    output parcel_t head_o,
    output parcel_t next_o,
    output logic [1:0] cnt_o
);

    parcel_t    buf_q [3];
    parcel_t    buf_d [3];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic [1:0] pop_n;
    logic [1:0] push_n;
    logic [1:0] surv_cnt;

    always_comb begin
        buf_d    = buf_q;
        pop_n    = pop_i;
        push_n   = push_i;
        surv_cnt = cnt_q - pop_n;

        case (pop_i)
            MOVE_ONE: begin
                buf_d[0] = buf_q[1];
                buf_d[1] = buf_q[2];
            end
            MOVE_TWO: buf_d[0] = buf_q[2];
            default: ;
        endcase

        // Appends only happen when at most one parcel survives, so both new
        // parcels always fit inside the three entries.
        for (int i = 0; i < 3; i++) begin
            if (push_n != 2'd0 && 2'(i) == surv_cnt) begin
                buf_d[i] = push_lo_i;
            end
            if (push_n == 2'd2 && 2'(i) == surv_cnt + 2'd1) begin
                buf_d[i] = push_hi_i;
            end
        end

        cnt_d = surv_cnt + push_n;
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Parcel storage carries no reset; stale entries are hidden by the count.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign head_o = buf_q[0];
    assign next_o = buf_q[1];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/airi5c_fetch_aligner.sv
// Fetch aligner: splits aligned 32-bit fetch words into parcels and re-assembles
// one raw (possibly compressed) instruction per handshake, with its PC.
module airi5c_fetch_aligner
    import airi5c_fetch_aligner_pkg::*;
#(
    parameter int                 XPR_LEN  = 32,
    parameter logic [XPR_LEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [XPR_LEN-1:0] fetch_data_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic               redirect_i,
    input  logic [XPR_LEN-1:0] redirect_pc_i,
    output logic [XPR_LEN-1:0] instr_o,
    output logic [XPR_LEN-1:0] instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic               instr_is_c_o
);

    logic [XPR_LEN-1:0] pc_q;
    logic [XPR_LEN-1:0] pc_d;
    logic               skip_q;
    logic               skip_d;

    parcel_t    head;
    parcel_t    next;
    logic [1:0] cnt;
    logic       head_c;
    logic       accept;
    logic       consume;
    move_e      pop_move;
    move_e      push_move;
    parcel_t    push_lo;
    parcel_t    push_hi;

    airi5c_fetch_aligner_parcel_buffer u_parcel_buffer (
        .clk       (clk),
        .nreset    (nreset),
        .flush_i   (redirect_i),
        .pop_i     (pop_move),
        .push_i    (push_move),
        .push_lo_i (push_lo),
        .push_hi_i (push_hi),
        .head_o    (head),
        .next_o    (next),
        .cnt_o     (cnt)
    );

    assign head_c = is_compressed(head);

    // Readiness looks only at the registered count and the redirect, never at
    // downstream ready, so the fetch side sees no combinational loop.
    assign fetch_ready_o = (cnt <= 2'd1) && !redirect_i;
    assign accept        = fetch_valid_i && fetch_ready_o;

    assign instr_valid_o = ((cnt >= 2'd1) && head_c) || (cnt >= 2'd2);
    assign instr_is_c_o  = (cnt != 2'd0) && head_c;
    assign instr_pc_o    = pc_q;
    assign consume       = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        instr_o = '0;
        if (cnt >= 2'd2) begin
            instr_o = {next, head};
        end else if (cnt == 2'd1) begin
            instr_o = {{(XPR_LEN-RVC_PARCEL_W){1'b0}}, head};
        end
    end

    always_comb begin
        pop_move  = MOVE_NONE;
        push_move = MOVE_NONE;
        push_lo   = fetch_data_i[RVC_PARCEL_W-1:0];
        push_hi   = fetch_data_i[XPR_LEN-1:RVC_PARCEL_W];
        pc_d      = pc_q;
        skip_d    = skip_q;

        if (consume) begin
            pop_move = head_c ? MOVE_ONE : MOVE_TWO;
            pc_d     = pc_q + (head_c ? XPR_LEN'(2) : XPR_LEN'(4));
        end

        // After a redirect to an odd-parcel target, the lower parcel of the
        // first word belongs to the old stream and is dropped.
        if (accept) begin
            skip_d = 1'b0;
            if (skip_q) begin
                push_move = MOVE_ONE;
                push_lo   = fetch_data_i[XPR_LEN-1:RVC_PARCEL_W];
            end else begin
                push_move = MOVE_TWO;
            end
        end

        if (redirect_i) begin
            pc_d   = {redirect_pc_i[XPR_LEN-1:1], 1'b0};
            skip_d = redirect_pc_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pc_q   <= RESET_PC;
            skip_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            skip_q <= skip_d;
        end
    end

endmodule

// File: tb/tb_airi5c_fetch_aligner.sv
// Directed bench for the fetch aligner: each step drives inputs, lets them settle
// and compares outputs against hand-computed values.
module tb_airi5c_fetch_aligner;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] fetch_data_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        instr_is_c_o;

    int checks   = 0;
    int failures = 0;

    airi5c_fetch_aligner dut (
        .clk           (clk),
        .nreset        (nreset),
        .fetch_data_i  (fetch_data_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_is_c_o  (instr_is_c_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: valid, ready, is_c, instr, pc.
    task automatic chk_out(input string tag, input logic v, input logic r, input logic c,
                           input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v});
        chk({tag, ".fready"}, {31'd0, fetch_ready_o}, {31'd0, r});
        chk({tag, ".is_c"}, {31'd0, instr_is_c_o}, {31'd0, c});
        chk({tag, ".instr"}, instr_o, ins);
        chk({tag, ".pc"}, instr_pc_o, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset        = 1'b0;
        fetch_valid_i = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        #1;
    endtask

    initial begin
        fetch_data_i  = 32'h0;
        redirect_pc_i = 32'h0;

        // Reset state
        do_reset();
        chk_out("reset", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0000);

        // Two 32-bit instructions back to back
        fetch_valid_i = 1'b1; fetch_data_i = 32'h00A0_0093; instr_ready_i = 1'b1;
        tick();
        fetch_data_i = 32'h0010_8113;
        #1;
        chk_out("t1.i0", 1'b1, 1'b0, 1'b0, 32'h00A0_0093, 32'h8000_0000);
        tick();
        chk_out("t1.gap", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0004);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t1.i1", 1'b1, 1'b0, 1'b0, 32'h0010_8113, 32'h8000_0004);
        tick();
        chk("t1.pc_end", instr_pc_o, 32'h8000_0008);

        // Two compressed parcels in one word
        do_reset();
        fetch_valid_i = 1'b1; fetch_data_i = 32'h4585_0505; instr_ready_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t2.c0", 1'b1, 1'b0, 1'b1, 32'h4585_0505, 32'h8000_0000);
        tick();
        chk_out("t2.c1", 1'b1, 1'b1, 1'b1, 32'h0000_4585, 32'h8000_0002);
        tick();
        chk_out("t2.end", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0004);

        // 32-bit instruction straddling two words
        do_reset();
        fetch_valid_i = 1'b1; fetch_data_i = 32'h0093_0505; instr_ready_i = 1'b1;
        tick();
        fetch_data_i = 32'h1234_00A0;
        #1;
        chk_out("t3.c0", 1'b1, 1'b0, 1'b1, 32'h0093_0505, 32'h8000_0000);
        tick();
        chk_out("t3.half", 1'b0, 1'b1, 1'b0, 32'h0000_0093, 32'h8000_0002);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t3.span", 1'b1, 1'b0, 1'b0, 32'h00A0_0093, 32'h8000_0002);
        tick();
        instr_ready_i = 1'b0;
        #1;
        chk_out("t3.hold0", 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h8000_0006);
        tick();
        chk_out("t3.hold1", 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h8000_0006);

        // Fill to three parcels, then redirect to an odd-parcel target
        fetch_valid_i = 1'b1; fetch_data_i = 32'hAAAA_BBBB;
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t4.cnt3", 1'b1, 1'b0, 1'b1, 32'hBBBB_1234, 32'h8000_0006);
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0103;
        fetch_valid_i = 1'b1; fetch_data_i = 32'h4505_FFFF; instr_ready_i = 1'b1;
        #1;
        chk_out("t4.redir", 1'b1, 1'b0, 1'b1, 32'hBBBB_1234, 32'h8000_0006);
        tick();
        redirect_i = 1'b0;
        #1;
        chk_out("t4.flushed", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0102);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t4.skip", 1'b1, 1'b1, 1'b1, 32'h0000_4505, 32'h8000_0102);
        tick();
        chk_out("t4.end", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0104);

        // Backpressure with a continuous fetch stream
        do_reset();
        fetch_valid_i = 1'b1; fetch_data_i = 32'h00A0_0093; instr_ready_i = 1'b0;
        tick();
        fetch_data_i = 32'h4585_0505;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_out($sformatf("t5.stall%0d", i), 1'b1, 1'b0, 1'b0, 32'h00A0_0093, 32'h8000_0000);
            tick();
        end
        instr_ready_i = 1'b1;
        tick();
        chk_out("t5.drain", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0004);
        tick();
        fetch_data_i = 32'h0010_8113;
        #1;
        chk_out("t5.w1c0", 1'b1, 1'b0, 1'b1, 32'h4585_0505, 32'h8000_0004);
        tick();
        chk_out("t5.w1c1", 1'b1, 1'b1, 1'b1, 32'h0000_4585, 32'h8000_0006);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t5.w2", 1'b1, 1'b0, 1'b0, 32'h0010_8113, 32'h8000_0008);
        tick();
        chk_out("t5.end", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_000C);

        // Reset mid-stream with two parcels buffered
        fetch_valid_i = 1'b1; fetch_data_i = 32'h00A0_0093; instr_ready_i = 1'b0;
        tick();
        fetch_valid_i = 1'b0;
        #1;
        chk_out("t6.pre", 1'b1, 1'b0, 1'b0, 32'h00A0_0093, 32'h8000_000C);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        #1;
        chk_out("t6.post", 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0000);

        // PC wraps past the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0; fetch_valid_i = 1'b1; fetch_data_i = 32'h0001_1111;
        tick();
        fetch_valid_i = 1'b0; instr_ready_i = 1'b1;
        #1;
        chk_out("t7.top", 1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
        tick();
        chk_out("t7.wrap", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
